// File: rtl/pixel_stream_ctrl.sv
// pixel_stream_ctrl: streams a frame buffer to a UART transmitter in host-requested chunks
module pixel_stream_ctrl #(
    parameter int         IMAGE_SIZE = 76800,
    parameter int         CHUNK_SIZE = 320,
    parameter logic [7:0] CMD_START  = 8'h52,
    parameter logic [7:0] CMD_ABORT  = 8'h58,
    parameter int         ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_rd_en,
    input  logic [7:0]        pix_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] bytes_sent
);
    localparam int                CW         = CHUNK_SIZE > 1 ? $clog2(CHUNK_SIZE) : 1;
    localparam logic [ADDR_W-1:0] LAST_BYTE  = ADDR_W'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0]     LAST_CHUNK = CW'(CHUNK_SIZE - 1);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, SEND, WAIT_CMD} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [CW-1:0]     chunk_q, chunk_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              abort_q, abort_d;
    logic              done_q, done_d;
    logic              rx_start, rx_abort, xfer;
    assign rx_start   = rx_valid && rx_data == CMD_START;
    assign rx_abort   = rx_valid && rx_data == CMD_ABORT;
    assign xfer       = state_q == SEND && tx_ready;
    // Read address and transferred-byte count always advance together, so one register serves both
    assign pix_addr   = pos_q;
    assign bytes_sent = pos_q;
    assign pix_rd_en  = state_q == FETCH;
    assign tx_valid   = state_q == SEND;
    assign tx_data    = tx_data_q;
    assign busy       = state_q != IDLE;
    assign frame_done = done_q;
    // Next-state and datapath updates; end-of-frame is tested before a pending abort so the last byte always finishes the frame
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        chunk_d   = chunk_q;
        tx_data_d = tx_data_q;
        abort_d   = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_start) begin
                    state_d = FETCH;
                    pos_d   = '0;
                    chunk_d = '0;
                end
            end
            FETCH: state_d = rx_abort ? IDLE : WAIT_DATA;
            WAIT_DATA: begin
                tx_data_d = pix_data;
                state_d   = rx_abort ? IDLE : SEND;
            end
            SEND: begin
                if (xfer) begin
                    pos_d   = pos_q + ADDR_W'(1);
                    chunk_d = chunk_q == LAST_CHUNK ? '0 : chunk_q + CW'(1);
                    if (pos_q == LAST_BYTE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (abort_q || rx_abort) begin
                        state_d = IDLE;
                    end else begin
                        state_d = chunk_q == LAST_CHUNK ? WAIT_CMD : FETCH;
                    end
                end else begin
                    abort_d = abort_q || rx_abort;
                end
            end
            WAIT_CMD: state_d = rx_abort ? IDLE : rx_start ? FETCH : WAIT_CMD;
            default: state_d = IDLE;
        endcase
    end
    // State and datapath registers; reset discards any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            chunk_q   <= '0;
            tx_data_q <= '0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            chunk_q   <= chunk_d;
            tx_data_q <= tx_data_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// tb_pixel_stream_ctrl: directed checks of two pixel_stream_ctrl instances (8-byte and 10-byte frames, 4-byte chunks)
module tb_pixel_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rx_data [2];
    logic        rx_valid [2];
    logic [16:0] pix_addr [2];
    logic        pix_rd_en [2];
    logic [7:0]  pix_data [2];
    logic [7:0]  tx_data [2];
    logic        tx_valid [2];
    logic        tx_ready [2];
    logic        busy [2];
    logic        frame_done [2];
    logic [16:0] bytes_sent [2];
    int          checks = 0;
    int          failures = 0;
    int          m_mode [2];
    int          m_t [2];
    int          m_pos [2];
    bit          m_ab [2];
    bit          m_done [2];
    int          xfers [2];
    int          rds [2];
    int          dones [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        pixel_stream_ctrl #(.IMAGE_SIZE(g ? 10 : 8), .CHUNK_SIZE(4)) dut (
            .clk(clk), .rst_n(rst_n), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
            .pix_addr(pix_addr[g]), .pix_rd_en(pix_rd_en[g]), .pix_data(pix_data[g]),
            .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
            .busy(busy[g]), .frame_done(frame_done[g]), .bytes_sent(bytes_sent[g])
        );
    end

    function automatic logic [7:0] pix(input int a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic bit is_cmd(input int g, input logic [7:0] c);
        return rx_valid[g] && rx_data[g] == c;
    endfunction

    // Frame buffer: data one cycle after the read strobe, garbage otherwise
    always @(posedge clk)
        for (int g = 0; g < 2; g++) pix_data[g] <= pix_rd_en[g] ? pix(int'(pix_addr[g])) : 8'hEE;

    // Event tallies used by the literal checks
    always @(posedge clk)
        for (int g = 0; g < 2; g++) begin
            xfers[g] <= xfers[g] + int'(tx_valid[g] && tx_ready[g]);
            rds[g]   <= rds[g] + int'(pix_rd_en[g]);
            dones[g] <= dones[g] + int'(frame_done[g]);
        end

    // Reference model: m_t counts cycles since a request/transfer (1 = read strobe, 3+ = byte offered)
    always @(posedge clk or negedge rst_n)
        for (int g = 0; g < 2; g++) begin
            m_done[g] <= 1'b0;
            if (!rst_n) begin
                m_mode[g] <= 0;
                m_t[g]    <= 0;
                m_pos[g]  <= 0;
                m_ab[g]   <= 1'b0;
            end else if (m_mode[g] == 0) begin
                if (is_cmd(g, 8'h52)) begin
                    m_mode[g] <= 1;
                    m_t[g]    <= 1;
                    m_pos[g]  <= 0;
                end
            end else if (m_mode[g] == 2) begin
                if (is_cmd(g, 8'h58)) m_mode[g] <= 0;
                else if (is_cmd(g, 8'h52)) begin
                    m_mode[g] <= 1;
                    m_t[g]    <= 1;
                end
            end else if (m_t[g] < 3) begin
                if (is_cmd(g, 8'h58)) m_mode[g] <= 0;
                else m_t[g] <= m_t[g] + 1;
            end else if (tx_ready[g]) begin
                m_pos[g] <= m_pos[g] + 1;
                m_ab[g]  <= 1'b0;
                if (m_pos[g] + 1 == (g ? 10 : 8)) begin
                    m_mode[g] <= 0;
                    m_done[g] <= 1'b1;
                end else if (m_ab[g] || is_cmd(g, 8'h58)) m_mode[g] <= 0;
                else if ((m_pos[g] + 1) % 4 == 0) m_mode[g] <= 2;
                else m_t[g] <= 1;
            end else if (is_cmd(g, 8'h58)) m_ab[g] <= 1'b1;
        end

    task automatic chk(input string n, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d exp=%0d at %0t", n, g, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            chk("busy", g, busy[g], int'(m_mode[g] != 0));
            chk("pix_rd_en", g, pix_rd_en[g], int'(m_mode[g] == 1 && m_t[g] == 1));
            chk("tx_valid", g, tx_valid[g], int'(m_mode[g] == 1 && m_t[g] >= 3));
            chk("frame_done", g, frame_done[g], int'(m_done[g]));
            chk("bytes_sent", g, int'(bytes_sent[g]), m_pos[g]);
            if (pix_rd_en[g]) chk("pix_addr", g, int'(pix_addr[g]), m_pos[g]);
            if (tx_valid[g]) chk("tx_data", g, tx_data[g], pix(m_pos[g]));
            if (!rst_n) begin
                chk("rst_tx_data", g, tx_data[g], 0);
                chk("rst_pix_addr", g, int'(pix_addr[g]), 0);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input logic [7:0] b);
        rx_data[g]  = b;
        rx_valid[g] = 1'b1;
        tick();
        rx_valid[g] = 1'b0;
        rx_data[g]  = 8'h00;
    endtask

    task automatic wait_valid(input int g);
        for (int n = 0; n < 20 && !tx_valid[g]; n++) tick();
        chk("wait_valid", g, tx_valid[g], 1);
    endtask

    task automatic wait_sent(input int g, input int v);
        for (int n = 0; n < 60 && int'(bytes_sent[g]) != v; n++) tick();
        chk("wait_sent", g, int'(bytes_sent[g]), v);
    endtask

    task automatic wait_done(input int g);
        for (int n = 0; n < 60 && !frame_done[g]; n++) tick();
        chk("wait_done", g, frame_done[g], 1);
    endtask

    // Directed scenarios
    initial begin
        int r;
        for (int g = 0; g < 2; g++) begin
            rx_data[g]  = 8'h00;
            rx_valid[g] = 1'b0;
            tx_ready[g] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_busy", 0, busy[0], 0);
        chk("reset_rd", 0, pix_rd_en[0], 0);
        chk("reset_valid", 0, tx_valid[0], 0);
        chk("reset_addr", 0, int'(pix_addr[0]), 0);
        chk("reset_sent", 0, int'(bytes_sent[0]), 0);
        chk("reset_txd", 0, tx_data[0], 0);
        chk("reset_done", 0, frame_done[0], 0);
        send(0, 8'h12);
        chk("filter_busy", 0, busy[0], 0);
        chk("filter_rd", 0, pix_rd_en[0], 0);
        tick();
        send(0, 8'h52);
        chk("start_rd", 0, pix_rd_en[0], 1);
        chk("start_addr", 0, int'(pix_addr[0]), 0);
        tick();
        chk("n2_valid", 0, tx_valid[0], 0);
        tick();
        chk("n3_valid", 0, tx_valid[0], 1);
        chk("n3_data", 0, tx_data[0], 8'h0B);
        repeat (5) begin
            tick();
            chk("bp_valid", 0, tx_valid[0], 1);
            chk("bp_data", 0, tx_data[0], 8'h0B);
        end
        chk("bp_no_xfer", 0, xfers[0], 0);
        tx_ready[0] = 1'b1;
        tick();
        chk("bp_one_xfer", 0, xfers[0], 1);
        chk("bp_sent", 0, int'(bytes_sent[0]), 1);
        tick();
        tick();
        send(0, 8'h52);
        wait_sent(0, 4);
        chk("chunk_busy", 0, busy[0], 1);
        tick();
        tick();
        chk("wcmd_rd", 0, pix_rd_en[0], 0);
        chk("wcmd_sent", 0, int'(bytes_sent[0]), 4);
        send(0, 8'h12);
        chk("wcmd_ignore", 0, pix_rd_en[0], 0);
        send(0, 8'h52);
        chk("chunk2_rd", 0, pix_rd_en[0], 1);
        chk("chunk2_addr", 0, int'(pix_addr[0]), 4);
        wait_done(0);
        chk("frame_sent", 0, int'(bytes_sent[0]), 8);
        chk("frame_busy", 0, busy[0], 0);
        tick();
        chk("done_pulse", 0, frame_done[0], 0);
        chk("done_count", 0, dones[0], 1);
        chk("frame_xfers", 0, xfers[0], 8);
        tx_ready[0] = 1'b0;
        send(0, 8'h52);
        wait_valid(0);
        tx_ready[0] = 1'b1;
        tick();
        tx_ready[0] = 1'b0;
        wait_valid(0);
        tx_ready[0] = 1'b1;
        tick();
        tx_ready[0] = 1'b0;
        wait_valid(0);
        chk("ab_data2", 0, tx_data[0], 8'd85);
        chk("ab_sent2", 0, int'(bytes_sent[0]), 2);
        r = rds[0];
        send(0, 8'h58);
        chk("ab_hold", 0, tx_valid[0], 1);
        tick();
        tx_ready[0] = 1'b1;
        tick();
        tx_ready[0] = 1'b0;
        chk("ab_idle", 0, busy[0], 0);
        chk("ab_sent3", 0, int'(bytes_sent[0]), 3);
        repeat (4) tick();
        chk("ab_no_rd", 0, rds[0], r);
        chk("ab_no_done", 0, dones[0], 1);
        send(0, 8'h52);
        chk("fab_rd", 0, pix_rd_en[0], 1);
        send(0, 8'h58);
        chk("fab_idle", 0, busy[0], 0);
        tick();
        tx_ready[0] = 1'b1;
        send(0, 8'h52);
        wait_sent(0, 4);
        chk("wab_busy", 0, busy[0], 1);
        send(0, 8'h58);
        chk("wab_idle", 0, busy[0], 0);
        chk("wab_sent", 0, int'(bytes_sent[0]), 4);
        send(0, 8'h52);
        wait_sent(0, 4);
        send(0, 8'h52);
        wait_sent(0, 7);
        tx_ready[0] = 1'b0;
        wait_valid(0);
        chk("last_data", 0, tx_data[0], 8'd14);
        tx_ready[0] = 1'b1;
        send(0, 8'h58);
        tx_ready[0] = 1'b0;
        chk("last_done", 0, frame_done[0], 1);
        chk("last_sent", 0, int'(bytes_sent[0]), 8);
        chk("last_busy", 0, busy[0], 0);
        tx_ready[1] = 1'b1;
        send(1, 8'h52);
        chk("s_addr0", 1, int'(pix_addr[1]), 0);
        wait_sent(1, 4);
        tick();
        chk("s_wcmd1", 1, busy[1], 1);
        chk("s_wcmd1_rd", 1, pix_rd_en[1], 0);
        send(1, 8'h52);
        wait_sent(1, 8);
        tick();
        chk("s_wcmd2", 1, busy[1], 1);
        chk("s_wcmd2_valid", 1, tx_valid[1], 0);
        send(1, 8'h52);
        wait_done(1);
        chk("s_sent", 1, int'(bytes_sent[1]), 10);
        tick();
        chk("s_done_count", 1, dones[1], 1);
        chk("s_xfers", 1, xfers[1], 10);
        send(1, 8'h52);
        wait_sent(1, 4);
        send(1, 8'h52);
        wait_sent(1, 6);
        rst_n = 1'b0;
        tick();
        chk("r_busy", 1, busy[1], 0);
        chk("r_sent", 1, int'(bytes_sent[1]), 0);
        rst_n = 1'b1;
        tick();
        send(1, 8'h52);
        chk("r_rd", 1, pix_rd_en[1], 1);
        chk("r_addr", 1, int'(pix_addr[1]), 0);
        tick();
        tick();
        chk("r_data", 1, tx_data[1], 8'h0B);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_stream_ctrl.md
PIXEL_STREAM_CTRL -- requirements
Module: pixel_stream_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 76800, meaning pixels (bytes) per frame.
REQ-002 SHALL have parameter CHUNK_SIZE, default 320, meaning bytes sent per host request; legal range 1 <= CHUNK_SIZE <= IMAGE_SIZE.
REQ-003 SHALL have parameter CMD_START, default 8'h52, meaning host request byte.
REQ-004 SHALL have parameter CMD_ABORT, default 8'h58, meaning host abort byte.
REQ-005 SHALL have parameter ADDR_W, default 17, meaning pixel address width; ADDR_W >= clog2(IMAGE_SIZE).
REQ-006 SHALL have port clk, input, 1, meaning the single clock (50 MHz system clock).
REQ-007 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-008 SHALL have port rx_data, input, 8, meaning byte from the UART receiver.
REQ-009 SHALL have port rx_valid, input, 1, meaning one-cycle pulse qualifying rx_data.
REQ-010 SHALL have port pix_addr, output, ADDR_W, meaning frame-buffer read address.
REQ-011 SHALL have port pix_rd_en, output, 1, meaning frame-buffer read strobe.
REQ-012 SHALL have port pix_data, input, 8, meaning read data, valid exactly one cycle after pix_rd_en.
REQ-013 SHALL have port tx_data, output, 8, meaning byte to the UART transmitter.
REQ-014 SHALL have port tx_valid, output, 1, meaning tx_data is offered.
REQ-015 SHALL have port tx_ready, input, 1, meaning the transmitter accepts; a transfer occurs when tx_valid && tx_ready.
REQ-016 SHALL have port busy, output, 1, meaning state != IDLE.
REQ-017 SHALL have port frame_done, output, 1, meaning one-cycle pulse after the last frame byte transfers.
REQ-018 SHALL have port bytes_sent, output, ADDR_W, meaning count of bytes transferred in the current frame.

Function
REQ-019 SHALL implement states IDLE, FETCH, WAIT_DATA, SEND, WAIT_CMD.
REQ-020 IDLE SHALL move to FETCH with pix_addr=0 and bytes_sent=0 on rx_valid && rx_data==CMD_START, and ignore all other bytes.
REQ-021 FETCH SHALL assert pix_rd_en for exactly one cycle with the current pix_addr, then enter WAIT_DATA.
REQ-022 WAIT_DATA SHALL register pix_data into tx_data, then enter SEND.
REQ-023 SEND SHALL hold tx_valid=1 with tx_data stable until tx_ready=1; tx_valid is never withdrawn before a transfer.
REQ-024 On each transfer, the block SHALL increment pix_addr, bytes_sent and the chunk counter.
REQ-025 After each transfer, the block SHALL go to IDLE with frame_done pulsed next cycle if bytes_sent reaches IMAGE_SIZE; else to WAIT_CMD if the chunk counter reaches CHUNK_SIZE (chunk counter cleared); else to FETCH.
REQ-026 Latency SHALL be: CMD_START accepted at cycle N gives pix_rd_en at N+1 and tx_valid at N+3; transfer at cycle M gives next pix_rd_en at M+1 and next tx_valid at M+3.
REQ-027 WAIT_CMD SHALL move to FETCH, preserving pix_addr and bytes_sent, on CMD_START, and ignore other non-abort bytes.
REQ-028 CMD_START received in FETCH, WAIT_DATA or SEND SHALL be discarded and never queued.
REQ-029 CMD_ABORT in FETCH, WAIT_DATA or WAIT_CMD SHALL go to IDLE next cycle, with no further pix_rd_en and no frame_done.
REQ-030 CMD_ABORT in SEND SHALL set a pending flag; the in-flight byte completes its handshake, then the block goes to IDLE with no frame_done.
REQ-031 CMD_ABORT coinciding with the final transfer SHALL complete the frame normally, with frame_done pulsed.
REQ-032 If IMAGE_SIZE is not a multiple of CHUNK_SIZE, the final chunk SHALL be short and end the frame per REQ-025.
REQ-033 pix_addr SHALL never exceed IMAGE_SIZE-1 while pix_rd_en=1.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state IDLE, with pix_addr, pix_rd_en, tx_data, tx_valid, busy, frame_done, bytes_sent, chunk counter and abort flag all 0.
REQ-035 Reset mid-frame SHALL discard progress; the next CMD_START restarts at address 0.

Verification (IMAGE_SIZE=8, CHUNK_SIZE=4 unless stated)
REQ-036 Reset check: hold rst_n=0 for 5 cycles, release -> all outputs 0 and busy=0.
REQ-037 Command filter: send 0x12 in IDLE -> no pix_rd_en, busy=0; then send 0x52 at cycle N -> pix_rd_en with pix_addr=0 at N+1 and tx_valid at N+3 carrying pix_data for address 0.
REQ-038 Chunked frame: tx_ready=1 -> addresses 0..3 sent, then WAIT_CMD with bytes_sent=4; send 0x52 -> addresses 4..7 sent, then frame_done pulse, busy=0, bytes_sent=8; an extra 0x52 during SEND is ignored.
REQ-039 Backpressure: hold tx_ready=0 for 5 cycles in SEND -> tx_valid=1 and tx_data unchanged throughout; exactly one transfer occurs when tx_ready rises.
REQ-040 Abort: CMD_ABORT during SEND of byte 2 -> byte 2 completes, then IDLE, with no pix_rd_en for address 3 and no frame_done; CMD_ABORT in WAIT_CMD -> IDLE next cycle.
REQ-041 Short chunk and reset: with IMAGE_SIZE=10, CHUNK_SIZE=4 -> chunks of 4, 4 and 2, then frame_done; rst_n pulse after 6 bytes, then 0x52 -> restart at pix_addr=0.
